// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, constants and state encoding for the fetch stage.
// Macro FETCH_MISALIGN_EXC_EN widens buffer entries with a misalign flag.
package fetch_pkg;
    localparam int INSTR_W = 32;
    localparam int ADDR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;
    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_1000;
    typedef enum logic [1:0] {FS_REQ = 2'd0, FS_WAIT = 2'd1, FS_DROP = 2'd2} fetch_state_e;
`ifdef FETCH_MISALIGN_EXC_EN
    localparam int ENTRY_W = INSTR_W + ADDR_W + 1;
`else
    localparam int ENTRY_W = INSTR_W + ADDR_W;
`endif
endpackage

// File: rtl/fetch_if.sv
// fetch_if: bundle of redirect, decode handshake and instruction memory signals.
// master = fetch stage view; slave = decode/memory/environment view.
// f_misalign exists only when FETCH_MISALIGN_EXC_EN is defined.
interface fetch_if;
    import fetch_pkg::*;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               d_stall;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ready;
    logic               imem_valid;
    logic [INSTR_W-1:0] imem_rdata;
    logic [INSTR_W-1:0] f_instr;
    logic [ADDR_W-1:0]  f_pc;
    logic               f_stall;
    logic               f_flush;
`ifdef FETCH_MISALIGN_EXC_EN
    logic               f_misalign;
    modport master (
        input  redirect_valid, redirect_pc, d_stall, imem_ready, imem_valid, imem_rdata,
        output imem_req, imem_addr, f_instr, f_pc, f_stall, f_flush, f_misalign
    );
    modport slave (
        output redirect_valid, redirect_pc, d_stall, imem_ready, imem_valid, imem_rdata,
        input  imem_req, imem_addr, f_instr, f_pc, f_stall, f_flush, f_misalign
    );
`else
    modport master (
        input  redirect_valid, redirect_pc, d_stall, imem_ready, imem_valid, imem_rdata,
        output imem_req, imem_addr, f_instr, f_pc, f_stall, f_flush
    );
    modport slave (
        output redirect_valid, redirect_pc, d_stall, imem_ready, imem_valid, imem_rdata,
        input  imem_req, imem_addr, f_instr, f_pc, f_stall, f_flush
    );
`endif
endinterface

// File: rtl/fetch_buffer.sv
// fetch_buffer: two-entry FIFO of fetched entries with push, pop and flush.
// Ports: clock, reset (async, active-high), push/pop/flush controls, din entry in,
// head entry out (valid when count != 0), count of held entries, full flag.
// Callers never push when full nor pop when empty.
module fetch_buffer import fetch_pkg::*; #(
    parameter int W = ENTRY_W,
    parameter int DEPTH = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic [1:0]   count,
    output logic         full
);
    logic [W-1:0] e1;
    assign full = count == 2'(DEPTH);
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
            head  <= '0;
            e1    <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            // on pop the head shifts from e1 when two are held, else takes din
            if (pop) head <= (count == 2'd2) ? e1 : din;
            else if (push && count == 2'd0) head <= din;
            if (push && (pop ? count == 2'd2 : count == 2'd1)) e1 <= din;
            count <= count + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC generation, single-outstanding instruction memory requests,
// redirect handling and a two-entry buffer feeding decode.
// Ports: clock, reset (async, active-high), bus (fetch_if.master) carrying
// redirect_valid/redirect_pc, d_stall, imem_req/addr/ready/valid/rdata,
// f_instr, f_pc, f_stall, f_flush and, with FETCH_MISALIGN_EXC_EN, f_misalign.
// FETCH_MISALIGN_EXC_EN: misaligned PCs push an exception entry and halt fetch
// until the next redirect; without it PC bits [1:0] are forced to zero on load.
module fetch_stage import fetch_pkg::*; #(
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int BUF_DEPTH = 2
) (
    input logic     clock,
    input logic     reset,
    fetch_if.master bus
);
    localparam logic [1:0] S_REQ  = FS_REQ;
    localparam logic [1:0] S_WAIT = FS_WAIT;
    localparam logic [1:0] S_DROP = FS_DROP;
    logic [1:0]         state, state_nx;
    logic [ADDR_W-1:0]  pc, pc_load;
    logic [1:0]         count;
    logic               full, resp, push, pop;
    logic [ENTRY_W-1:0] din, head;
`ifdef FETCH_MISALIGN_EXC_EN
    localparam logic [ADDR_W-1:0] PC0 = RESET_PC;
    logic halt, mis, mis_push;
    assign pc_load = bus.redirect_pc;
    assign mis = state == S_REQ && pc[1:0] != 2'b00;
    assign bus.imem_req = !reset && state == S_REQ && !full && !bus.redirect_valid && !halt && !mis;
    assign mis_push = mis && !halt && !full && !bus.redirect_valid;
    assign push = (resp && !bus.redirect_valid) || mis_push;
    assign din = mis_push ? {NOP_INSTR, pc, 1'b1} : {bus.imem_rdata, pc, 1'b0};
    assign {bus.f_instr, bus.f_pc} = (count == 2'd0) ? '0 : head[ENTRY_W-1:1];
    assign bus.f_misalign = count != 2'd0 && head[0];
    always_ff @(posedge clock or posedge reset) begin
        if (reset) halt <= 1'b0;
        else halt <= bus.redirect_valid ? 1'b0 : (mis_push ? 1'b1 : halt);
    end
`else
    localparam logic [ADDR_W-1:0] PC0 = {RESET_PC[ADDR_W-1:2], 2'b00};
    assign pc_load = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
    assign bus.imem_req = !reset && state == S_REQ && !full && !bus.redirect_valid;
    assign push = resp && !bus.redirect_valid;
    assign din = {bus.imem_rdata, pc};
    assign {bus.f_instr, bus.f_pc} = (count == 2'd0) ? '0 : head;
`endif
    assign bus.imem_addr = pc;
    assign bus.f_flush = bus.redirect_valid;
    assign bus.f_stall = count == 2'd0;
    assign resp = state == S_WAIT && bus.imem_valid;
    assign pop = count != 2'd0 && !bus.d_stall && !bus.redirect_valid;
    always_comb begin
        state_nx = state;
        // a redirect while a response is still owed must swallow that response
        if (bus.redirect_valid)
            state_nx = ((state == S_WAIT && !bus.imem_valid) || state == S_DROP) ? S_DROP : S_REQ;
        else if (state == S_REQ)
            state_nx = (bus.imem_req && bus.imem_ready) ? S_WAIT : S_REQ;
        else if (bus.imem_valid)
            state_nx = S_REQ;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_REQ;
            pc    <= PC0;
        end else begin
            state <= state_nx;
            if (bus.redirect_valid) pc <= pc_load;
            else if (resp) pc <= pc + ADDR_W'(4);
        end
    end
    fetch_buffer #(.W(ENTRY_W), .DEPTH(BUF_DEPTH)) u_buf (
        .clock(clock),
        .reset(reset),
        .push(push),
        .pop(pop),
        .flush(bus.redirect_valid),
        .din(din),
        .head(head),
        .count(count),
        .full(full)
    );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench; the expected program-order stream is queued
// at reset/redirect and a monitor compares every presented instruction.
module tb_fetch_stage;
    logic clock = 1'b0;
    logic reset = 1'b1;
    fetch_if bus();
    fetch_stage dut (.clock(clock), .reset(reset), .bus(bus));
    always #5 clock = ~clock;

    typedef struct packed {logic [31:0] pc; logic [31:0] instr; logic mis;} exp_t;
    exp_t sb[$];
    logic [31:0] sb_next;
    bit sb_halt;
    logic [31:0] acc_q[$];
    int total = 0, bad = 0, pops = 0;
    int lat = 1;
    bit mem_rand = 0;
    bit outst = 0, acc = 0;
    int left = 0;
    logic [31:0] maddr = 0, acc_addr = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC3A5_5A3C;
    endfunction

    function automatic void sb_fill();
        sb.push_back({sb_next, mem_word(sb_next), 1'b0});
        sb_next += 32'd4;
    endfunction

    function automatic void sb_restart(input logic [31:0] p);
        sb.delete();
        sb_halt = 0;
`ifdef FETCH_MISALIGN_EXC_EN
        if (p[1:0] != 2'b00) begin
            sb.push_back({p, 32'h0, 1'b1});
            sb_halt = 1;
            return;
        end
`else
        p[1:0] = 2'b00;
`endif
        sb_next = p;
        repeat (4) sb_fill();
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic redir(input logic [31:0] p);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = p;
        sb_restart(p);
    endtask

    // leaves the caller at the negedge where reset has just been released
    task automatic apply_reset(input int l, input bit r);
        @(negedge clock);
        reset = 1'b1;
        lat = l;
        mem_rand = r;
        bus.d_stall = 1'b0;
        bus.redirect_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        acc_q.delete();
        sb_restart(32'h0000_1000);
    endtask

    // memory: accepts when req&ready, answers lat cycles later, never back-pressured
    initial begin
        bus.imem_ready = 1'b0;
        bus.imem_valid = 1'b0;
        bus.imem_rdata = '0;
        forever begin
            @(negedge clock);
            if (bus.imem_valid) outst = 0;
            if (acc) begin
                outst = 1;
                maddr = acc_addr;
                left = (mem_rand ? $urandom_range(1, 3) : lat) - 1;
            end else if (outst) left--;
            if (reset) outst = 0;
            bus.imem_valid = outst && left == 0;
            bus.imem_rdata = bus.imem_valid ? mem_word(maddr) : $urandom;
            bus.imem_ready = mem_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            if (!reset && bus.imem_req) begin
                chk("one_outstanding", {31'b0, outst}, 32'h0);
                chk("req_align", {30'b0, bus.imem_addr[1:0]}, 32'h0);
            end
            acc = bus.imem_req && bus.imem_ready && !reset;
            if (acc) begin
                acc_addr = bus.imem_addr;
                acc_q.push_back(bus.imem_addr);
            end
        end
    end

    // monitor: compares presented head with the expected stream, pops on consume
    initial begin
        forever begin
            @(negedge clock);
            #1;
            if (!reset) begin
                chk("flush", {31'b0, bus.f_flush}, {31'b0, bus.redirect_valid});
                if (bus.f_stall) begin
                    chk("empty_pc", bus.f_pc, 32'h0);
                    chk("empty_instr", bus.f_instr, 32'h0);
                end else if (!bus.redirect_valid) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_head: got pc %h want none", bus.f_pc);
                    end else begin
                        chk("head_pc", bus.f_pc, sb[0].pc);
                        chk("head_instr", bus.f_instr, sb[0].instr);
`ifdef FETCH_MISALIGN_EXC_EN
                        chk("head_mis", {31'b0, bus.f_misalign}, {31'b0, sb[0].mis});
`endif
                        if (!bus.d_stall) begin
                            void'(sb.pop_front());
                            pops++;
                            if (!sb_halt) sb_fill();
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] st_exp;
        logic [31:0] rpc;
        int p0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0;
        bus.d_stall = 1'b0;
        // reset state
        @(negedge clock);
        #1;
        chk("rst_flush", {31'b0, bus.f_flush}, 32'h1);
        chk("rst_req", {31'b0, bus.imem_req}, 32'h0);
        chk("rst_stall", {31'b0, bus.f_stall}, 32'h1);
        chk("rst_instr", bus.f_instr, 32'h0);
        chk("rst_pc", bus.f_pc, 32'h0);
        @(negedge clock);
        bus.redirect_valid = 1'b0;
        #1;
        chk("rst_flush0", {31'b0, bus.f_flush}, 32'h0);

        // streaming with a 1-cycle memory: one instruction every other cycle
        apply_reset(1, 0);
        st_exp = 8'b1010_1011;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clock);
            #1;
            chk("t1_stall", {31'b0, bus.f_stall}, {31'b0, st_exp[c]});
        end
        chk("t1_nreq", {31'b0, acc_q.size() >= 3}, 32'h1);
        if (acc_q.size() >= 3) begin
            chk("t1_addr0", acc_q[0], 32'h1000);
            chk("t1_addr1", acc_q[1], 32'h1004);
            chk("t1_addr2", acc_q[2], 32'h1008);
        end

        // decode stall fills the buffer, then drains without loss
        apply_reset(1, 0);
        bus.d_stall = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clock);
            #1;
        end
        chk("t2_req", {31'b0, bus.imem_req}, 32'h0);
        chk("t2_hold_pc", bus.f_pc, 32'h1000);
        chk("t2_addr_hold", bus.imem_addr, 32'h1008);
        @(negedge clock);
        bus.d_stall = 1'b0;
        #1;
        chk("t2_first", bus.f_pc, 32'h1000);
        @(negedge clock);
        #1;
        chk("t2_second", bus.f_pc, 32'h1004);
        repeat (6) @(negedge clock);

        // redirect while waiting: late response dropped
        apply_reset(3, 0);
        #1;
        @(negedge clock);
        redir(32'h2000);
        #1;
        chk("t3_flush", {31'b0, bus.f_flush}, 32'h1);
        chk("t3_req_c1", {31'b0, bus.imem_req}, 32'h0);
        for (int c = 2; c <= 8; c++) begin
            @(negedge clock);
            bus.redirect_valid = 1'b0;
            #1;
            if (c < 8) chk("t3_stall", {31'b0, bus.f_stall}, 32'h1);
            if (c == 2 || c == 3) chk("t3_req_drop", {31'b0, bus.imem_req}, 32'h0);
            if (c == 4) begin
                chk("t3_req", {31'b0, bus.imem_req}, 32'h1);
                chk("t3_addr", bus.imem_addr, 32'h2000);
            end
        end
        chk("t3_pc", bus.f_pc, 32'h2000);
        chk("t3_present", {31'b0, bus.f_stall}, 32'h0);

        // redirect coincident with the response
        apply_reset(1, 0);
        #1;
        @(negedge clock);
        redir(32'h2400);
        #1;
        @(negedge clock);
        bus.redirect_valid = 1'b0;
        #1;
        chk("t4_req", {31'b0, bus.imem_req}, 32'h1);
        chk("t4_addr", bus.imem_addr, 32'h2400);
        chk("t4_stall", {31'b0, bus.f_stall}, 32'h1);
        repeat (4) @(negedge clock);

        // PC wrap
        apply_reset(1, 0);
        redir(32'hFFFF_FFFC);
        #1;
        chk("t5_req_c0", {31'b0, bus.imem_req}, 32'h0);
        @(negedge clock);
        bus.redirect_valid = 1'b0;
        #1;
        chk("t5_addr_c1", bus.imem_addr, 32'hFFFF_FFFC);
        repeat (2) @(negedge clock);
        #1;
        chk("t5_pc", bus.f_pc, 32'hFFFF_FFFC);
        chk("t5_wrap", bus.imem_addr, 32'h0);
        repeat (3) @(negedge clock);

        // reset during an outstanding request
        apply_reset(3, 0);
        #1;
        apply_reset(1, 0);
        repeat (5) @(negedge clock);
        chk("t6_nreq", {31'b0, acc_q.size() >= 1}, 32'h1);
        if (acc_q.size() >= 1) chk("t6_first", acc_q[0], 32'h1000);

        // misaligned redirect target
        apply_reset(1, 0);
        redir(32'h3002);
`ifdef FETCH_MISALIGN_EXC_EN
        bus.d_stall = 1'b1;
        @(negedge clock);
        bus.redirect_valid = 1'b0;
        #1;
        chk("t7_req_c1", {31'b0, bus.imem_req}, 32'h0);
        for (int c = 2; c <= 4; c++) begin
            @(negedge clock);
            #1;
            chk("t7_mis", {31'b0, bus.f_misalign}, 32'h1);
            chk("t7_instr", bus.f_instr, 32'h0);
            chk("t7_pc", bus.f_pc, 32'h3002);
            chk("t7_req", {31'b0, bus.imem_req}, 32'h0);
        end
        @(negedge clock);
        bus.d_stall = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            #1;
            chk("t7_halt_req", {31'b0, bus.imem_req}, 32'h0);
            chk("t7_halt_stall", {31'b0, bus.f_stall}, 32'h1);
        end
        @(negedge clock);
        redir(32'h1000);
        @(negedge clock);
        bus.redirect_valid = 1'b0;
        #1;
        chk("t7_resume_req", {31'b0, bus.imem_req}, 32'h1);
        chk("t7_resume_addr", bus.imem_addr, 32'h1000);
`else
        @(negedge clock);
        bus.redirect_valid = 1'b0;
        #1;
        chk("t7_req", {31'b0, bus.imem_req}, 32'h1);
        chk("t7_align", bus.imem_addr, 32'h3000);
`endif
        repeat (4) @(negedge clock);

        // randomized traffic against the program-order stream
        apply_reset(1, 1);
        p0 = pops;
        for (int i = 0; i < 3000; i++) begin
            bus.d_stall = $urandom_range(0, 2) == 0;
            if ($urandom_range(0, 24) == 0) begin
                rpc = $urandom;
`ifdef FETCH_MISALIGN_EXC_EN
                rpc[1:0] = 2'b00;
`endif
                if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF8;
                redir(rpc);
            end else begin
                bus.redirect_valid = 1'b0;
            end
            @(negedge clock);
        end
        bus.redirect_valid = 1'b0;
        bus.d_stall = 1'b0;
        repeat (12) @(negedge clock);
        chk("rand_progress", {31'b0, (pops - p0) > 100}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
